frog_collision: RTL
===================

Name: frog_collision

Overview:
Consumes the X/Y positions from the obstacle stages (truck lane and car lane) and the frog position. It performs a bounding-box overlap test every clock and runs the death, respawn and lives sequence. Its outputs feed the frog controller (freeze/respawn) and the HUD/game-state logic (lives, game over).

Parameters:
FROG_HALF, 8, frog half-width and half-height in pixels
TRUCK_HALF_W, 32, truck half-width (positions are centres)
TRUCK_HALF_H, 8, truck half-height
CAR_HALF_W, 16, car half-width
CAR_HALF_H, 8, car half-height
START_LIVES, 3, lives loaded at reset (1..3)
DEATH_CYCLES, 25000000, clocks the frog stays frozen after a hit
INVULN_CYCLES, 50000000, clocks of collision immunity after respawn

Ports:
frame_clk  input  1  system clock; all state changes on its rising edge
Reset  input  1  asynchronous, active-high reset
frogX  input  10  frog centre X
frogY  input  10  frog centre Y
truckX  input  10  truck centre X
truckY  input  10  truck centre Y
carX  input  10  car centre X
carY  input  10  car centre Y
hit  output  1  one-cycle pulse when a fatal collision is accepted
frozen  output  1  high while the frog must ignore movement input
respawn  output  1  one-cycle pulse commanding the frog back to its start position
lives  output  2  remaining lives
game_over  output  1  high once lives reach 0; sticky until Reset

Behaviour:
- Reset (async, active-high) forces state ALIVE, counter 0, lives=START_LIVES, and hit=frozen=respawn=game_over=0.
- Overlap test, combinational on the current inputs:
  - dx = |frogX - obsX| and dy = |frogY - obsY|, computed in 11 bits with no wrap.
  - Overlap with an obstacle when dx < FROG_HALF+obs_half_w AND dy < FROG_HALF+obs_half_h. Strict less-than: touching edges do not collide.
  - overlap = truck_overlap OR car_overlap. A simultaneous overlap with both obstacles counts as one hit.
- States:
  - ALIVE: frozen=0. If overlap is seen on a clock, on that edge: hit=1 for exactly one cycle, lives decrements by 1, counter clears. Next state is DYING, or GAME_OVER if lives was 1.
  - DYING: frozen=1 and overlap is ignored. Counter increments each clock. When counter reaches DEATH_CYCLES-1: respawn=1 for one cycle, counter clears, next state is INVULN.
  - INVULN: frozen=0 and overlap is ignored. Counter increments each clock. At INVULN_CYCLES-1: counter clears, next state is ALIVE.
  - GAME_OVER: game_over=1 and frozen=1. No further hit or respawn pulses and lives holds at 0. Only Reset exits.
- Latency: hit asserts on the first clock edge at which overlap is true in ALIVE. Outputs are registered, so hit is visible the following cycle. frozen rises on the same edge as hit.
- Lives never underflow. Lives are decremented only on hits accepted in ALIVE.
- Counter width is 26 bits, sufficient for both defaults. Counter saturation is not reachable by design.
- Reset asserted in any state, including mid-DYING or mid-INVULN, returns everything to reset values immediately, with no trailing respawn pulse.
- If the obstacle is still overlapping the respawn position when INVULN ends, a new hit is accepted in the first ALIVE cycle.

Test Plan:
- Reset, frog(300,400), truck(300,258), car(100,100): no overlap; hold 1000 cycles -> hit=0, lives=3, frozen=0.
- Truck(300,258), frogY=258, frogX=339 (dx=39<40) -> one hit pulse, lives=2, frozen=1. Repeat with frogX=340 (dx=40) -> no hit.
- Frog overlapping both truck and car on one cycle -> a single hit pulse, lives decrements by exactly 1.
- With DEATH_CYCLES=10 and INVULN_CYCLES=20, keep overlap asserted continuously:
  - Required sequence: hit; respawn exactly 10 cycles later; 20 cycles of no hit; then the second hit; lives=1.
- Three accepted hits from lives=3 -> lives=0, game_over=1, frozen=1. Further overlaps give no hit and no respawn pulses.
- Assert Reset 5 cycles into DYING -> lives=3, frozen=0, state ALIVE, and no respawn pulse afterwards.

Source files
------------

// File: rtl/frog_collision.sv
// Frog/obstacle bounding-box collision check plus the death, respawn and lives sequencer.
// All outputs are registered; dbg_state exposes the FSM state for checkers.
module frog_collision #(
    parameter int FROG_HALF     = 8,
    parameter int TRUCK_HALF_W  = 32,
    parameter int TRUCK_HALF_H  = 8,
    parameter int CAR_HALF_W    = 16,
    parameter int CAR_HALF_H    = 8,
    parameter int START_LIVES   = 3,
    parameter int DEATH_CYCLES  = 25000000,
    parameter int INVULN_CYCLES = 50000000
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] frogX,
    input  logic [9:0] frogY,
    input  logic [9:0] truckX,
    input  logic [9:0] truckY,
    input  logic [9:0] carX,
    input  logic [9:0] carY,
    output logic       hit,
    output logic       frozen,
    output logic       respawn,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [10:0] TRUCK_LIM_X = 11'(FROG_HALF + TRUCK_HALF_W);
    localparam logic [10:0] TRUCK_LIM_Y = 11'(FROG_HALF + TRUCK_HALF_H);
    localparam logic [10:0] CAR_LIM_X   = 11'(FROG_HALF + CAR_HALF_W);
    localparam logic [10:0] CAR_LIM_Y   = 11'(FROG_HALF + CAR_HALF_H);
    localparam logic [25:0] DEATH_LAST  = 26'(DEATH_CYCLES - 1);
    localparam logic [25:0] INVULN_LAST = 26'(INVULN_CYCLES - 1);

    state_t      state, state_next;
    logic [25:0] count, count_next;
    logic [1:0]  lives_next;
    logic        hit_d, respawn_d, frozen_d, game_over_d;
    logic        truck_overlap, car_overlap, overlap;

    // Magnitude of the difference, widened to 11 bits so it never wraps.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    always_comb begin
        truck_overlap = (abs_diff(frogX, truckX) < TRUCK_LIM_X) &&
                        (abs_diff(frogY, truckY) < TRUCK_LIM_Y);
        car_overlap   = (abs_diff(frogX, carX) < CAR_LIM_X) &&
                        (abs_diff(frogY, carY) < CAR_LIM_Y);
        overlap       = truck_overlap || car_overlap;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= ALIVE;
            count     <= '0;
            lives     <= 2'(START_LIVES);
            hit       <= 1'b0;
            respawn   <= 1'b0;
            frozen    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            lives     <= lives_next;
            hit       <= hit_d;
            respawn   <= respawn_d;
            frozen    <= frozen_d;
            game_over <= game_over_d;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        lives_next = lives;
        case (state)
            ALIVE: begin
                if (overlap) begin
                    count_next = '0;
                    lives_next = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    state_next = (lives <= 2'd1) ? GAME_OVER : DYING;
                end
            end
            DYING: begin
                if (count == DEATH_LAST) begin
                    count_next = '0;
                    state_next = INVULN;
                end else begin
                    count_next = count + 26'd1;
                end
            end
            INVULN: begin
                if (count == INVULN_LAST) begin
                    count_next = '0;
                    state_next = ALIVE;
                end else begin
                    count_next = count + 26'd1;
                end
            end
            default: begin
                count_next = '0;
                state_next = GAME_OVER;
            end
        endcase
    end

    // Registered outputs are decoded from the current state and the state being entered.
    always_comb begin
        hit_d       = (state == ALIVE) && overlap;
        respawn_d   = (state == DYING) && (count == DEATH_LAST);
        frozen_d    = (state_next == DYING) || (state_next == GAME_OVER);
        game_over_d = (state_next == GAME_OVER);
    end

    assign dbg_state = state;

endmodule
